// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO: synchronised, debounced inputs with sticky rising-edge flags
// and a maskable interrupt, plus a set/clear-able output register for LEDs.
module gpio_mmio #(
  parameter int unsigned N_IN     = 8,
  parameter int unsigned N_OUT    = 8,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CNT_W    = $clog2(DEBOUNCE + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              we,
  input  logic [4:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [N_IN-1:0]   gpio_in,
  output logic [N_OUT-1:0]  gpio_out,
  output logic              irq
);

  localparam logic [2:0] REG_IN      = 3'd0;
  localparam logic [2:0] REG_OUT     = 3'd1;
  localparam logic [2:0] REG_OUT_SET = 3'd2;
  localparam logic [2:0] REG_OUT_CLR = 3'd3;
  localparam logic [2:0] REG_EDGE    = 3'd4;
  localparam logic [2:0] REG_IRQ_EN  = 3'd5;

  logic [N_IN-1:0]  s1_q, s1_d;
  logic [N_IN-1:0]  s2_q, s2_d;
  logic [N_IN-1:0]  stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [N_IN];
  logic [CNT_W-1:0] cnt_d [N_IN];
  logic [N_OUT-1:0] out_q, out_d;
  logic [N_IN-1:0]  edge_q, edge_d;
  logic [N_IN-1:0]  irq_en_q, irq_en_d;
  logic [N_IN-1:0]  edge_clr;
  logic [2:0]       reg_idx;
  logic             wr;
  logic             unused_c;

  assign reg_idx  = addr[4:2];
  assign wr       = sel & we;
  assign unused_c = ^{addr[1:0], wdata};

  // Next-state: synchroniser, per-bit debouncer, bus writes, edge flags
  always_comb begin
    s1_d     = gpio_in;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    irq_en_d = irq_en_q;
    edge_clr = '0;

    for (int i = 0; i < int'(N_IN); i++) begin
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(DEBOUNCE - 1)) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    if (wr) begin
      case (reg_idx)
        REG_OUT:     out_d    = wdata[N_OUT-1:0];
        REG_OUT_SET: out_d    = out_q | wdata[N_OUT-1:0];
        REG_OUT_CLR: out_d    = out_q & ~wdata[N_OUT-1:0];
        REG_EDGE:    edge_clr = wdata[N_IN-1:0];
        REG_IRQ_EN:  irq_en_d = wdata[N_IN-1:0];
        default:     ;
      endcase
    end

    // A rising edge landing on the same cycle as a W1C clear keeps the flag set
    edge_d = (edge_q & ~edge_clr) | (stable_d & ~stable_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      for (int i = 0; i < int'(N_IN); i++) cnt_q[i] <= '0;
      out_q    <= '0;
      edge_q   <= '0;
      irq_en_q <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      edge_q   <= edge_d;
      irq_en_q <= irq_en_d;
    end
  end

  // Read mux, combinational from addr; idle bus reads zero
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (reg_idx)
        REG_IN:     rdata = 32'(stable_q);
        REG_OUT:    rdata = 32'(out_q);
        REG_EDGE:   rdata = 32'(edge_q);
        REG_IRQ_EN: rdata = 32'(irq_en_q);
        default:    rdata = '0;
      endcase
    end
  end

  assign gpio_out = out_q;
  assign irq      = |(edge_q & irq_en_q);

endmodule
